// File: rtl/gray_pack_pkg.sv
// Shared widths, FIFO entry layout and flush FSM states for the gray pixel packer.
package gray_pack_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
    localparam int unsigned IDX_W          = 2;
    localparam int unsigned BCNT_W         = 3;
    localparam int unsigned ENTRY_W        = WORD_W + BCNT_W;

    // Byte index of the last byte in a word; reaching it completes the word.
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BYTES_PER_WORD - 1);

    // One buffered word: packed pixels (big-endian) plus number of valid pixels.
    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [BCNT_W-1:0] bcnt;
    } fifo_entry_t;

    // Flush handling: FLUSH_WAIT holds a partial word until the FIFO has room.
    typedef enum logic [0:0] {
        IDLE_OR_PACKING = 1'b0,
        FLUSH_WAIT      = 1'b1
    } flush_state_e;

    // Pointer width for a power-of-two FIFO depth (at least one bit).
    function automatic int unsigned ptr_width(input int unsigned depth);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < depth) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/gray_word_fifo.sv
// Synchronous word FIFO holding packed pixel words with their byte counts.
module gray_word_fifo
    import gray_pack_pkg::*;
#(
    parameter  int unsigned FIFO_DEPTH = 4,
    localparam int unsigned PTR_W      = ptr_width(FIFO_DEPTH),
    localparam int unsigned CNT_W      = PTR_W + 1
) (
    input  logic              clock,
    input  logic              nReset,
    input  logic              push_i,
    input  fifo_entry_t       push_entry_i,
    input  logic              pop_i,
    output fifo_entry_t       head_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o
);

    fifo_entry_t            mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [CNT_W-1:0]       count_q;
    logic                   do_push;
    logic                   do_pop;

    // Guard the handshakes so a stray push on full or pop on empty is harmless.
    always_comb begin
        full_o  = (count_q == CNT_W'(FIFO_DEPTH));
        empty_o = (count_q == '0);
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        count_o = count_q;
        head_o  = mem_q[rd_ptr_q];
    end

    // Storage array, pointers (wrap naturally at power-of-two depth) and occupancy.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_entry_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/gray_pixel_packer.sv
// Packs 8-bit gray pixels four to a big-endian 32-bit word and buffers the words.
module gray_pixel_packer
    import gray_pack_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clock,
    input  logic                nReset,
    input  logic                pixelValid,
    input  logic [BYTE_W-1:0]   pixelData,
    output logic                pixelReady,
    input  logic                flush,
    output logic                wordValid,
    output logic [WORD_W-1:0]   wordData,
    output logic [BCNT_W-1:0]   wordByteCount,
    input  logic                wordReady,
    output logic                busy
);

    localparam int unsigned CNT_W = ptr_width(FIFO_DEPTH) + 1;

    flush_state_e           state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [WORD_W-1:0]      asm_q, asm_d;

    logic                   accept;
    logic                   word_done;
    logic [IDX_W-1:0]       idx_after;
    logic [WORD_W-1:0]      asm_merged;

    logic                   fifo_push;
    fifo_entry_t            fifo_push_entry;
    logic                   fifo_pop;
    fifo_entry_t            fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;

    // Handshake and status decode from registered state only.
    always_comb begin
        pixelReady    = (state_q != FLUSH_WAIT) && ((idx_q != IDX_LAST) || !fifo_full);
        accept        = pixelValid && pixelReady;
        wordValid     = !fifo_empty;
        wordData      = fifo_empty ? '0 : fifo_head.data;
        wordByteCount = fifo_empty ? '0 : fifo_head.bcnt;
        fifo_pop      = wordValid && wordReady;
        busy          = (idx_q != '0) || (fifo_count != '0) || (state_q == FLUSH_WAIT);
    end

    // Merge an accepted pixel into its big-endian byte lane.
    always_comb begin
        asm_merged = asm_q;
        idx_after  = idx_q;
        word_done  = 1'b0;
        if (accept) begin
            case (idx_q)
                IDX_W'(0): asm_merged[31:24] = pixelData;
                IDX_W'(1): asm_merged[23:16] = pixelData;
                IDX_W'(2): asm_merged[15:8]  = pixelData;
                default:   asm_merged[7:0]   = pixelData;
            endcase
            word_done = (idx_q == IDX_LAST);
            idx_after = idx_q + IDX_W'(1);
        end
    end

    // Next state and FIFO push: full words first, then immediate or deferred flush.
    always_comb begin
        state_d              = state_q;
        idx_d                = idx_after;
        asm_d                = asm_merged;
        fifo_push            = 1'b0;
        fifo_push_entry      = '0;
        case (state_q)
            IDLE_OR_PACKING: begin
                if (word_done) begin
                    // A completing pixel absorbs a coincident flush.
                    fifo_push            = 1'b1;
                    fifo_push_entry.data = asm_merged;
                    fifo_push_entry.bcnt = BCNT_W'(BYTES_PER_WORD);
                    asm_d                = '0;
                end else if (flush && (idx_after != '0)) begin
                    if (!fifo_full) begin
                        fifo_push            = 1'b1;
                        fifo_push_entry.data = asm_merged;
                        fifo_push_entry.bcnt = BCNT_W'(idx_after);
                        asm_d                = '0;
                        idx_d                = '0;
                    end else begin
                        state_d = FLUSH_WAIT;
                    end
                end
            end
            FLUSH_WAIT: begin
                // No pixels are accepted here, so asm_q/idx_q are the partial word.
                if (!fifo_full) begin
                    fifo_push            = 1'b1;
                    fifo_push_entry.data = asm_q;
                    fifo_push_entry.bcnt = BCNT_W'(idx_q);
                    asm_d                = '0;
                    idx_d                = '0;
                    state_d              = IDLE_OR_PACKING;
                end
            end
            default: begin
                state_d = IDLE_OR_PACKING;
            end
        endcase
    end

    // Flush FSM state register.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE_OR_PACKING;
        end else begin
            state_q <= state_d;
        end
    end

    // Assembly word and byte index registers.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            idx_q <= '0;
            asm_q <= '0;
        end else begin
            idx_q <= idx_d;
            asm_q <= asm_d;
        end
    end

    gray_word_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_word_fifo (
        .clock        (clock),
        .nReset       (nReset),
        .push_i       (fifo_push),
        .push_entry_i (fifo_push_entry),
        .pop_i        (fifo_pop),
        .head_o       (fifo_head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_o      (fifo_count)
    );

endmodule

// File: tb/tb_gray_pixel_packer.sv
// Scoreboard bench for gray_pixel_packer: a byte-packing model queues expected words.
module tb_gray_pixel_packer;

    logic        clock = 1'b0;
    logic        nReset = 1'b0;
    logic        pixelValid = 1'b0;
    logic [7:0]  pixelData = 8'h00;
    logic        pixelReady;
    logic        flush = 1'b0;
    logic        wordValid;
    logic [31:0] wordData;
    logic [2:0]  wordByteCount;
    logic        wordReady = 1'b0;
    logic        busy;

    int          vectors = 0;
    int          miscompares = 0;

    logic [34:0] exp_q [$];
    logic [31:0] m_word = '0;
    int          m_idx = 0;

    gray_pixel_packer #(
        .FIFO_DEPTH (4)
    ) dut (
        .clock         (clock),
        .nReset        (nReset),
        .pixelValid    (pixelValid),
        .pixelData     (pixelData),
        .pixelReady    (pixelReady),
        .flush         (flush),
        .wordValid     (wordValid),
        .wordData      (wordData),
        .wordByteCount (wordByteCount),
        .wordReady     (wordReady),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Model: pack accepted pixels, close partial words on flush, check popped words.
    always @(negedge clock) begin
        logic [34:0] e;
        bit          done;
        if (!nReset) begin
            exp_q.delete();
            m_word = '0;
            m_idx  = 0;
        end else begin
            if (wordValid && wordReady) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_word", 32'(wordValid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("word_data", wordData, e[34:3]);
                    check_eq("word_bcnt", 32'(wordByteCount), 32'(e[2:0]));
                end
            end
            done = 1'b0;
            if (pixelValid && pixelReady) begin
                m_word[8*(3-m_idx) +: 8] = pixelData;
                m_idx++;
                if (m_idx == 4) begin
                    exp_q.push_back({m_word, 3'd4});
                    m_word = '0;
                    m_idx  = 0;
                    done   = 1'b1;
                end
            end
            if (flush && !done && m_idx != 0) begin
                exp_q.push_back({m_word, 3'(m_idx)});
                m_word = '0;
                m_idx  = 0;
            end
        end
    end

    task automatic send_pixel(input logic [7:0] d, input logic with_flush);
        bit ok;
        ok         = 1'b0;
        pixelValid = 1'b1;
        pixelData  = d;
        flush      = with_flush;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clock);
            if (pixelReady) ok = 1'b1;
            @(posedge clock);
            #1;
        end
        pixelValid = 1'b0;
        flush      = 1'b0;
        if (!ok) check_eq("accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit ok;
        ok        = 1'b0;
        wordReady = 1'b1;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clock);
            if (!busy) ok = 1'b1;
        end
        check_eq(tag, 32'(ok), 32'd1);
        check_eq({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  acc;

        // Reset values
        #12;
        check_eq("rst_wordValid", 32'(wordValid), 32'd0);
        check_eq("rst_wordData", wordData, 32'd0);
        check_eq("rst_wordByteCount", 32'(wordByteCount), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_pixelReady", 32'(pixelReady), 32'd1);
        @(posedge clock);
        #1;
        nReset = 1'b1;

        // 1: four back-to-back pixels form one word
        wordReady = 1'b1;
        send_pixel(8'h11, 1'b0);
        send_pixel(8'h22, 1'b0);
        send_pixel(8'h33, 1'b0);
        send_pixel(8'h44, 1'b0);
        check_eq("t1_wordValid", 32'(wordValid), 32'd1);
        check_eq("t1_wordData", wordData, 32'h11223344);
        check_eq("t1_bcnt", 32'(wordByteCount), 32'd4);
        @(posedge clock);
        #1;
        check_eq("t1_busy_after_pop", 32'(busy), 32'd0);
        check_eq("t1_empty_after_pop", 32'(wordValid), 32'd0);

        // 2: partial word via flush, then flush with nothing held
        send_pixel(8'hAA, 1'b0);
        send_pixel(8'hBB, 1'b0);
        pulse_flush();
        check_eq("t2_wordValid", 32'(wordValid), 32'd1);
        check_eq("t2_wordData", wordData, 32'hAABB0000);
        check_eq("t2_bcnt", 32'(wordByteCount), 32'd2);
        drain("t2_drain");
        pulse_flush();
        check_eq("t2_noop_wordValid", 32'(wordValid), 32'd0);
        check_eq("t2_noop_busy", 32'(busy), 32'd0);
        @(posedge clock);
        #1;
        check_eq("t2_noop_wordValid2", 32'(wordValid), 32'd0);

        // 3: backpressure, 19 of 20 pixels accepted, then release
        wordReady  = 1'b0;
        n          = 0;
        pixelValid = 1'b1;
        pixelData  = 8'h00;
        for (int c = 0; c < 40 && n < 20; c++) begin
            @(negedge clock);
            acc = pixelReady;
            @(posedge clock);
            #1;
            if (acc) begin
                n++;
                pixelData = 8'(n);
            end
        end
        check_eq("t3_accepted", 32'(n), 32'd19);
        check_eq("t3_pixelReady", 32'(pixelReady), 32'd0);
        check_eq("t3_head", wordData, 32'h00010203);
        check_eq("t3_busy", 32'(busy), 32'd1);
        wordReady = 1'b1;
        send_pixel(8'h13, 1'b0);
        drain("t3_drain");

        // 4: flush while FIFO full waits for room
        wordReady = 1'b0;
        for (int i = 0; i < 16; i++) send_pixel(8'(8'h20 + i), 1'b0);
        send_pixel(8'h5A, 1'b0);
        pulse_flush();
        check_eq("t4_pixelReady_pending", 32'(pixelReady), 32'd0);
        check_eq("t4_busy_pending", 32'(busy), 32'd1);
        wordReady = 1'b1;
        @(posedge clock);
        #1;
        wordReady = 1'b0;
        check_eq("t4_pixelReady_after_pop", 32'(pixelReady), 32'd0);
        @(posedge clock);
        #1;
        check_eq("t4_pixelReady_after_push", 32'(pixelReady), 32'd1);
        check_eq("t4_busy_after_push", 32'(busy), 32'd1);
        drain("t4_drain");

        // 5: flush coincident with a pixel
        wordReady = 1'b1;
        send_pixel(8'h01, 1'b0);
        send_pixel(8'h02, 1'b0);
        send_pixel(8'h03, 1'b0);
        send_pixel(8'h04, 1'b1);
        check_eq("t5_full_data", wordData, 32'h01020304);
        check_eq("t5_full_bcnt", 32'(wordByteCount), 32'd4);
        drain("t5a_drain");
        send_pixel(8'h01, 1'b0);
        send_pixel(8'h02, 1'b1);
        check_eq("t5_part_data", wordData, 32'h01020000);
        check_eq("t5_part_bcnt", 32'(wordByteCount), 32'd2);
        drain("t5b_drain");

        // 6: asynchronous reset mid-stream
        wordReady = 1'b0;
        for (int i = 0; i < 14; i++) send_pixel(8'(8'h30 + i), 1'b0);
        #2;
        nReset = 1'b0;
        #1;
        check_eq("t6_wordValid", 32'(wordValid), 32'd0);
        check_eq("t6_wordData", wordData, 32'd0);
        check_eq("t6_bcnt", 32'(wordByteCount), 32'd0);
        check_eq("t6_busy", 32'(busy), 32'd0);
        check_eq("t6_pixelReady", 32'(pixelReady), 32'd1);
        @(negedge clock);
        @(posedge clock);
        #1;
        nReset    = 1'b1;
        wordReady = 1'b1;
        send_pixel(8'hC1, 1'b0);
        send_pixel(8'hC2, 1'b0);
        send_pixel(8'hC3, 1'b0);
        send_pixel(8'hC4, 1'b0);
        check_eq("t6_fresh_data", wordData, 32'hC1C2C3C4);
        drain("t6_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
